i2c_slave_rx: RTL
=================

Name: i2c_slave_rx

Overview:
- Write-only I2C target receiver, downstream of the I2C master on the same bus.
- Oversamples SCL/SDA on the fast system clock and detects START, repeated START and STOP.
- Shifts in the 7-bit address and R/W bit, ACKs on a match, then receives data bytes. Each byte is handed to the local logic with a one-cycle valid pulse.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit address this target answers to.
- RW_WRITE, 1'b1, R/W bit value treated as a write. Our master sends 1 for write. Any other value is NACKed.
- FILT_LEN, 3, stable-sample count for the glitch filter. Used only with the optional feature; legal range 2..15.

Ports:
- clk  input  1  system clock; must be at least 8x the SCL frequency
- reset_n  input  1  asynchronous, active-low reset
- scl_in  input  1  bus SCL, asynchronous
- sda_in  input  1  bus SDA, asynchronous
- sda_oe  output  1  1 = pull SDA low (ACK); 0 = release. The top level ties the pad to 0 when sda_oe is 1.
- rx_ready  input  1  local sink can accept a byte
- rx_data  output  8  last received byte, MSB first on the wire
- rx_valid  output  1  one-cycle pulse; rx_data is valid while it is high
- busy  output  1  high from an address match until STOP
- stop_seen  output  1  one-cycle pulse on a STOP that ends an addressed transfer
- nack_out  output  1  one-cycle pulse whenever a NACK is given on an addressed byte

Behaviour:
- Reset, asynchronous on reset_n low:
  - State IDLE; shift register and bit counter cleared.
  - Outputs: sda_oe=0, rx_data=8'h00, rx_valid=0, busy=0, stop_seen=0, nack_out=0.
  - Synchronizer flops preset to 1.
- Input conditioning:
  - scl_in and sda_in each pass through a 2-flop synchronizer, then one history flop.
  - Edges (scl_rise, scl_fall, sda_rise, sda_fall) are 1-cycle pulses, 3 clk after the pin change.
- Bus conditions, evaluated every cycle with priority STOP > START > SCL edges:
  - START: sda_fall while synchronized SCL is high.
  - STOP: sda_rise while synchronized SCL is high.
- States: IDLE, ADDR, ACK_A, DATA, ACK_D, IGNORE.
- Transitions:
  - IDLE: on START go to ADDR, with bit count=0.
  - ADDR: sample SDA on each scl_rise into shreg[7:0], MSB first. After the 8th rise, compare shreg[7:1] with SLAVE_ADDR and shreg[0] with RW_WRITE.
    - Match: set busy and go to ACK_A.
    - Mismatch: go to IGNORE.
  - ACK_A: set sda_oe=1 on the first scl_fall and hold it through the 9th SCL high. Clear sda_oe on the next scl_fall, then go to DATA with count=0.
  - DATA: sample 8 bits the same way. On the 8th scl_rise, load rx_data from the shifted byte.
    - If rx_ready=1 on that cycle: pulse rx_valid on the following clk.
    - Then go to ACK_D.
  - ACK_D:
    - Byte accepted: drive ACK exactly as in ACK_A.
    - Byte refused (rx_ready was 0): sda_oe stays 0, nack_out pulses, and the byte is dropped with no rx_valid.
    - Either way, return to DATA on the closing scl_fall.
  - IGNORE: sda_oe=0; ignore everything except START/STOP.
- From any non-IDLE state:
  - START (repeated) goes to ADDR; busy clears, and sets again only on a new match.
  - STOP goes to IDLE and clears busy and sda_oe. It pulses stop_seen if busy was 1.
- Abnormal conditions:
  - STOP or START in mid-byte: the partial byte is discarded; no rx_valid.
  - STOP during ACK drive: sda_oe releases on the same cycle the STOP is detected.
  - Address mismatch gives no nack_out; only addressed bytes report NACK.
  - There is no clock stretching: SCL is never driven.
- Latency: rx_valid occurs 4 clk after the SCL rising pin edge of the data LSB.

Optional Feature:
- Macro I2C_SLAVE_RX_GLITCH_FILTER_EN.
- Defined: each synchronized line passes through a filter. The filter updates its output only after the input has held a new value for FILT_LEN consecutive clk. Pulses shorter than FILT_LEN clk are suppressed, and all edge latencies grow by FILT_LEN clk.
- Undefined: no filter; synchronizer output feeds edge detection directly, and FILT_LEN is unused.

Test Plan:
- Write, address match: START, 0x50 with RW=1, data 0xA5, rx_ready=1, STOP.
  - sda_oe low during both 9th clocks.
  - One rx_valid with rx_data=8'hA5.
  - busy high from address ACK to STOP; one stop_seen pulse.
- Address mismatch: START, address 0x51, data 0x3C, STOP.
  - sda_oe never 1; no rx_valid; busy stays 0; no stop_seen; no nack_out.
- Back-pressure: two bytes 0x11 and 0x22, with rx_ready=0 during the second byte.
  - 0x11 is ACKed with rx_valid.
  - 0x22 is NACKed (SDA released on the 9th clock), nack_out pulses once, no second rx_valid.
- Repeated START: START, 0x50, byte 0x7E, then a repeated START mid-transfer after 4 bits, 0x50, 0x81, STOP.
  - Exactly two rx_valid pulses, with data 0x7E then 0x81; the partial byte is dropped.
- Reset mid-transfer: assert reset_n low during bit 3 of a data byte, with no clk edge.
  - sda_oe, busy and rx_valid go to 0 immediately.
  - After release, a fresh START/0x50/0x5A transfer completes normally.
- Glitch filter (I2C_SLAVE_RX_GLITCH_FILTER_EN, FILT_LEN=3):
  - A 2-clk SCL low glitch during a data bit is not counted; byte 0xC3 is received intact.
  - Without the macro, the same glitch corrupts the bit count.

Source files
------------

// File: rtl/i2c_slave_rx.sv
// Write-only I2C target receiver: START/STOP detection, address match, per-byte ACK/NACK.
// Optional SCL/SDA glitch filter enabled by defining I2C_SLAVE_RX_GLITCH_FILTER_EN.
module i2c_slave_rx #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h50,
    parameter logic        RW_WRITE   = 1'b1,
    parameter int unsigned FILT_LEN   = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       stop_seen,
    output logic       nack_out
);
    localparam int unsigned CNT_W = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        ACK_A  = 3'd2,
        DATA   = 3'd3,
        ACK_D  = 3'd4,
        IGNORE = 3'd5
    } state_t;

    if ((FILT_LEN < 2) || (FILT_LEN > 15)) begin : g_filt_len_check
        $error("i2c_slave_rx: FILT_LEN must be in 2..15");
    end

    // Bit 0 carries SCL, bit 1 carries SDA through the conditioning chain.
    logic [1:0] sync1, sync2, cond, hist;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
        end else begin
            sync1 <= {sda_in, scl_in};
            sync2 <= sync1;
        end
    end

`ifdef I2C_SLAVE_RX_GLITCH_FILTER_EN
    localparam int unsigned FCNT_W = 4;
    logic [FCNT_W-1:0] fcnt [2];

    // Output follows the input only after FILT_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cond <= 2'b11;
            for (int i = 0; i < 2; i++) fcnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == cond[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FCNT_W'(FILT_LEN - 1)) begin
                    cond[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + FCNT_W'(1);
                end
            end
        end
    end
`else
    assign cond = sync2;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) hist <= 2'b11;
        else          hist <= cond;
    end

    logic scl_rise_c, scl_fall_c, sda_rise_c, sda_fall_c, start_c, stop_c;
    assign scl_rise_c = cond[0] & ~hist[0];
    assign scl_fall_c = ~cond[0] & hist[0];
    assign sda_rise_c = cond[1] & ~hist[1];
    assign sda_fall_c = ~cond[1] & hist[1];
    assign start_c    = sda_fall_c & cond[0];
    assign stop_c     = sda_rise_c & cond[0];

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [7:0]       shreg, shreg_d, rx_data_d, byte_c;
    logic             acc, acc_d, ack_ph, ack_ph_d, valid_pend, valid_pend_d;
    logic             sda_oe_d, busy_d, stop_seen_d, nack_d;

    assign byte_c = {shreg[6:0], cond[1]};

    // Next-state and next-output logic; STOP beats START beats SCL edges.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        shreg_d      = shreg;
        acc_d        = acc;
        ack_ph_d     = ack_ph;
        valid_pend_d = 1'b0;
        sda_oe_d     = sda_oe;
        rx_data_d    = rx_data;
        busy_d       = busy;
        stop_seen_d  = 1'b0;
        nack_d       = 1'b0;
        if (stop_c) begin
            state_d     = IDLE;
            busy_d      = 1'b0;
            sda_oe_d    = 1'b0;
            ack_ph_d    = 1'b0;
            stop_seen_d = busy;
        end else if (start_c) begin
            state_d  = ADDR;
            cnt_d    = '0;
            shreg_d  = '0;
            busy_d   = 1'b0;
            sda_oe_d = 1'b0;
            ack_ph_d = 1'b0;
        end else begin
            case (state)
                ADDR: if (scl_rise_c) begin
                    shreg_d = byte_c;
                    if (cnt == CNT_W'(7)) begin
                        ack_ph_d = 1'b0;
                        if ((byte_c[7:1] == SLAVE_ADDR) && (byte_c[0] == RW_WRITE)) begin
                            busy_d  = 1'b1;
                            state_d = ACK_A;
                        end else begin
                            state_d = IGNORE;
                        end
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
                DATA: if (scl_rise_c) begin
                    shreg_d = byte_c;
                    if (cnt == CNT_W'(7)) begin
                        rx_data_d    = byte_c;
                        acc_d        = rx_ready;
                        valid_pend_d = rx_ready;
                        ack_ph_d     = 1'b0;
                        state_d      = ACK_D;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
                ACK_A, ACK_D: if (scl_fall_c) begin
                    if (!ack_ph) begin
                        ack_ph_d = 1'b1;
                        sda_oe_d = (state == ACK_A) ? 1'b1 : acc;
                        nack_d   = (state == ACK_D) & ~acc;
                    end else begin
                        ack_ph_d = 1'b0;
                        sda_oe_d = 1'b0;
                        cnt_d    = '0;
                        state_d  = DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            acc        <= 1'b0;
            ack_ph     <= 1'b0;
            valid_pend <= 1'b0;
            sda_oe     <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            busy       <= 1'b0;
            stop_seen  <= 1'b0;
            nack_out   <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            shreg      <= shreg_d;
            acc        <= acc_d;
            ack_ph     <= ack_ph_d;
            valid_pend <= valid_pend_d;
            sda_oe     <= sda_oe_d;
            rx_data    <= rx_data_d;
            rx_valid   <= valid_pend;
            busy       <= busy_d;
            stop_seen  <= stop_seen_d;
            nack_out   <= nack_d;
        end
    end
endmodule
